mips_scoreboard_regfile: RTL and testbench
==========================================

// Module: mips_scoreboard_regfile
// PURPOSE
//  Register file with a built-in write scoreboard, for the 5-stage MIPS core. It has NRD read ports
//  and one write port, with same-cycle write-through bypass. For each register it counts in-flight
//  writes: Decode issues a destination, Writeback retires it. Decode uses rd_pending to detect
//  hazards and stall. Register 0 always reads as zero. A debug port exposes any register.
// PARAMETERS
//  DATA_W  32  register width in bits
//  ADDR_W  5   address width; the file holds 2**ADDR_W registers
//  NRD     2   number of read ports
//  PEND_W  2   width of each in-flight counter; at most 2**PEND_W-1 outstanding writes per register
// PORTS
//  clock       in   1           rising-edge clock
//  reset       in   1           synchronous, active-high
//  rd_addr     in   NRD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
//  rd_data     out  NRD*DATA_W  read data, combinational
//  rd_pending  out  NRD         1 = the addressed register still has an outstanding write
//  iss_en      in   1           Decode issues an instruction that will write iss_addr
//  iss_addr    in   ADDR_W      destination register of the issue
//  iss_ready   out  1           0 = iss_addr counter is saturated; Decode must stall
//  wr_en       in   1           Writeback retires a write
//  wr_addr     in   ADDR_W      Writeback destination
//  wr_data     in   DATA_W      Writeback value
//  dbg_addr    in   ADDR_W      debug read address
//  dbg_data    out  DATA_W      debug read data, combinational, no bypass
//  err_uflow   out  1           sticky; set when a retire arrives for a register whose counter is 0
// BEHAVIOUR
//  - Reset (synchronous):
//    - clears every register, every counter and err_uflow;
//    - a reset cycle ignores iss_en and wr_en.
//  - Storage: when wr_en=1 and wr_addr!=0, mem[wr_addr] <= wr_data at the clock edge.
//    - The value is visible from storage the next cycle.
//  - Read port i:
//    - addr 0 -> 0.
//    - Otherwise, if wr_en and wr_addr==addr -> wr_data (same-cycle bypass).
//    - Otherwise -> mem[addr].
//  - Counters cnt[r], for r != 0:
//    - Increment on an accepted issue (iss_en & iss_ready, iss_addr==r).
//    - Decrement on a retire (wr_en, wr_addr==r, cnt[r]!=0).
//    - If both happen to the same r in one cycle, cnt[r] is unchanged.
//    - cnt[0] is held at 0; issues and retires to r0 are ignored and never raise err_uflow.
//  - iss_ready = (iss_addr==0) | (cnt[iss_addr] != 2**PEND_W-1) | (wr_en & wr_addr==iss_addr).
//    - A retire in the same cycle frees a slot.
//    - If iss_en=1 while iss_ready=0, the issue is dropped and no state changes.
//  - rd_pending[i] = 1 when (cnt[a] minus the same-cycle retire to a) != 0, where a is port i's address.
//    - An operand that is being written back this cycle is therefore not pending (its value comes via the bypass).
//    - rd_pending[i] is 0 for address 0.
//  - Underflow: when wr_en=1, wr_addr!=0 and cnt[wr_addr]==0 (and no same-cycle issue to wr_addr),
//    the data is still written, the counter stays 0, and err_uflow is set until reset.
//  - Reset mid-operation: every in-flight count is discarded. The pipeline must be flushed at the same time.
//  - All ports are independent and may all address the same register in the same cycle.
//  - No output is registered except through mem, cnt and err_uflow.
// TESTING
//  1. Reset, then read all ports at addr 5 -> rd_data=0, rd_pending=0, iss_ready=1, err_uflow=0.
//  2. Issue r5, next cycle retire r5 with 0xDEADBEEF.
//     -> rd_pending[0]=1 in between; on the retire cycle rd_data[0]=0xDEADBEEF (bypass) and rd_pending[0]=0;
//        the cycle after, the value comes from storage.
//  3. Issue r7 three times with PEND_W=2 -> iss_ready=0.
//     -> a 4th issue is dropped; a retire of r7 plus an issue of r7 in the same cycle keeps cnt=3.
//  4. Write 0x1234 to r0 and issue r0 -> rd_data=0, rd_pending=0, err_uflow stays 0.
//  5. Retire r9 with cnt=0 -> mem[9] is updated and err_uflow=1, which holds until reset.
//  6. Issue r3 twice, then assert reset -> next cycle rd_pending=0, dbg_data for r3 = 0.

Source files
------------

// File: rtl/mips_scoreboard_regfile.sv
// Register file with per-register in-flight write counters for the 5-stage MIPS core.
// Read ports bypass a same-cycle writeback; the debug port reads storage only.
module mips_scoreboard_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int PEND_W = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_pending,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  output logic                  iss_ready,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [ADDR_W-1:0]     dbg_addr,
  output logic [DATA_W-1:0]     dbg_data,
  output logic                  err_uflow
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] mem [NREG];
  logic [PEND_W-1:0] cnt [NREG];

  logic wr_live;
  logic iss_take;
  logic iss_match_wr;

  // Issue handshake: an issue is accepted in a cycle where iss_en and iss_ready
  // are both high; with iss_ready low the issue is dropped and Decode must hold it.
  assign wr_live      = wr_en && (wr_addr != '0);
  assign iss_ready    = (iss_addr == '0) || (cnt[iss_addr] != CNT_MAX) ||
                        (wr_en && (wr_addr == iss_addr));
  assign iss_take     = iss_en && iss_ready && (iss_addr != '0);
  assign iss_match_wr = iss_take && wr_live && (iss_addr == wr_addr);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        mem[r] <= '0;
        cnt[r] <= '0;
      end
      err_uflow <= 1'b0;
    end else begin
      if (wr_live) begin
        mem[wr_addr] <= wr_data;
      end
      cnt[0] <= '0;
      for (int r = 1; r < NREG; r++) begin
        if (iss_take && (iss_addr == ADDR_W'(r)) && !iss_match_wr) begin
          cnt[r] <= cnt[r] + 1'b1;
        end else if (wr_live && (wr_addr == ADDR_W'(r)) && !iss_match_wr &&
                     (cnt[r] != '0)) begin
          cnt[r] <= cnt[r] - 1'b1;
        end
      end
      // A retire paired with an issue to the same register is a matched slot, not an underflow.
      if (wr_live && (cnt[wr_addr] == '0) && !iss_match_wr) begin
        err_uflow <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [PEND_W-1:0] cnt_a;
    logic              hit;
    logic              ret;

    assign a     = rd_addr[i*ADDR_W +: ADDR_W];
    assign cnt_a = cnt[a];
    assign hit   = wr_en && (wr_addr == a);
    assign ret   = hit && (cnt_a != '0);

    assign rd_data[i*DATA_W +: DATA_W] = (a == '0) ? '0 :
                                         hit        ? wr_data : mem[a];
    assign rd_pending[i] = (a != '0) && ((cnt_a - PEND_W'(ret)) != '0);
  end

  assign dbg_data = mem[dbg_addr];

endmodule

// File: tb/tb_mips_scoreboard_regfile.sv
// Randomized bench for mips_scoreboard_regfile against an array/integer reference model,
// with expected outputs queued by the driver and compared by a negedge monitor.
module tb_mips_scoreboard_regfile;

  localparam int EXP_W = 100;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_pending;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        iss_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        err_uflow;

  mips_scoreboard_regfile dut (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_pending(rd_pending), .iss_en(iss_en), .iss_addr(iss_addr),
    .iss_ready(iss_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .err_uflow(err_uflow)
  );

  always #5 clock = ~clock;

  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int passed = 0;

  // Reference model state
  logic [31:0] m_mem [32];
  int          m_cnt [32];
  bit          m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  function automatic logic [31:0] rd_m(input logic [4:0] a, input logic we,
                                       input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return 32'h0;
    if (we && wa == a) return wd;
    return m_mem[a];
  endfunction

  function automatic logic pend_m(input logic [4:0] a, input logic we, input logic [4:0] wa);
    int left;
    if (a == 0) return 1'b0;
    left = m_cnt[a];
    if (we && wa == a && left > 0) left = left - 1;
    return left != 0;
  endfunction

  function automatic logic ready_m(input logic [4:0] ia, input logic we, input logic [4:0] wa);
    return (ia == 0) || (m_cnt[ia] != 3) || (we && wa == ia);
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      m_mem[r] = 32'h0;
      m_cnt[r] = 0;
    end
    m_err = 1'b0;
  endtask

  task automatic step(input logic rst, input logic ie, input logic [4:0] ia,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] ra0, input logic [4:0] ra1,
                      input logic [4:0] da, input bit chk);
    logic rdy;
    bit   acc;
    bit   ret;
    @(posedge clock);
    #1;
    reset = rst; iss_en = ie; iss_addr = ia; wr_en = we; wr_addr = wa;
    wr_data = wd; rd_addr = {ra1, ra0}; dbg_addr = da;
    rdy = ready_m(ia, we, wa);
    if (chk) begin
      exp_q.push_back({rd_m(ra0, we, wa, wd), rd_m(ra1, we, wa, wd),
                       pend_m(ra1, we, wa), pend_m(ra0, we, wa), rdy,
                       m_mem[da], m_err});
    end
    if (rst) begin
      model_clear();
    end else begin
      acc = ie && rdy && ia != 0;
      ret = we && wa != 0;
      if (ret) m_mem[wa] = wd;
      if (!(acc && ret && ia == wa)) begin
        if (acc) m_cnt[ia] = m_cnt[ia] + 1;
        if (ret) begin
          if (m_cnt[wa] == 0) m_err = 1'b1;
          else m_cnt[wa] = m_cnt[wa] - 1;
        end
      end
    end
  endtask

  // Monitor: one expected record per driven cycle, compared mid-cycle.
  initial begin
    logic [EXP_W-1:0] e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rd_data0",   rd_data[31:0],          e[99:68]);
        check("rd_data1",   rd_data[63:32],         e[67:36]);
        check("rd_pending", {30'h0, rd_pending},    {30'h0, e[35:34]});
        check("iss_ready",  {31'h0, iss_ready},     {31'h0, e[33]});
        check("dbg_data",   dbg_data,               e[32:1]);
        check("err_uflow",  {31'h0, err_uflow},     {31'h0, e[0]});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] ra0;
    logic [4:0] ra1;
    reset = 1'b1; iss_en = 0; iss_addr = 0; wr_en = 0; wr_addr = 0;
    wr_data = 0; rd_addr = 0; dbg_addr = 0;
    model_clear();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Reset state, all ports at r5
    step(0, 0, 5, 0, 0, 0, 5, 5, 5, 1);
    // Issue r5, pending gap, bypassed retire, then storage read
    step(0, 1, 5, 0, 0, 0, 5, 5, 5, 1);
    step(0, 0, 0, 0, 0, 0, 5, 5, 5, 1);
    step(0, 0, 0, 1, 5, 32'hDEADBEEF, 5, 0, 5, 1);
    step(0, 0, 0, 0, 0, 0, 5, 5, 5, 1);
    // Saturate r7, dropped 4th issue, matched retire+issue keeps 3
    for (int k = 0; k < 3; k++) step(0, 1, 7, 0, 0, 0, 7, 7, 7, 1);
    step(0, 1, 7, 0, 0, 0, 7, 7, 7, 1);
    step(0, 1, 7, 1, 7, 32'h77, 7, 7, 7, 1);
    step(0, 0, 7, 0, 0, 0, 7, 7, 7, 1);
    for (int k = 0; k < 3; k++) step(0, 0, 7, 1, 7, 32'h70 + k, 7, 0, 7, 1);
    step(0, 0, 7, 0, 0, 0, 7, 7, 7, 1);
    // r0 writes and issues are ignored
    step(0, 1, 0, 1, 0, 32'h1234, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Underflow retire of r9 still writes and latches the error
    step(0, 0, 0, 1, 9, 32'h9999, 9, 1, 9, 1);
    step(0, 0, 0, 0, 0, 0, 9, 1, 9, 1);
    step(0, 0, 0, 0, 0, 0, 9, 1, 9, 1);
    // Reset discards in-flight counts
    step(0, 1, 3, 1, 3, 32'h3333, 3, 3, 3, 1);
    step(0, 1, 3, 0, 0, 0, 3, 3, 3, 1);
    step(0, 1, 3, 0, 0, 0, 3, 3, 3, 1);
    step(1, 0, 0, 0, 0, 0, 3, 3, 3, 1);
    step(0, 0, 3, 0, 0, 0, 3, 3, 3, 1);
    // Randomized traffic on a small register window to force collisions
    for (int n = 0; n < 800; n++) begin
      ra0 = 5'($urandom_range(0, 7));
      ra1 = 5'($urandom_range(0, 7));
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 55),
           5'($urandom_range(0, 7)), ($urandom_range(0, 99) < 40),
           5'($urandom_range(0, 7)), $urandom, ra0, ra1,
           5'($urandom_range(0, 7)), 1);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
